// File: rtl/fs2_redirect_ctrl.sv
// Fetch-2 next-PC check: selects the first taken control lane, redirects
// Fetch-1 on a next-PC mismatch and queues BTB misses of direct branches.
module fs2_redirect_ctrl #(
   parameter int FETCH_WIDTH     = 4,
   parameter int SIZE_PC         = 64,
   parameter int BRANCH_TYPE_LOG = 2,
   parameter int UPD_DEPTH       = 4
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 flush_i,
   input  logic                                 fs2Valid_i,
   input  logic                                 stall_i,
   input  logic [SIZE_PC-1:0]                   pc_i,
   input  logic [FETCH_WIDTH-1:0]               laneValid_i,
   input  logic [FETCH_WIDTH-1:0]               ctrlInst_i,
   input  logic [FETCH_WIDTH*BRANCH_TYPE_LOG-1:0] ctrlType_i,
   input  logic [FETCH_WIDTH*SIZE_PC-1:0]       predNPC_i,
   input  logic [FETCH_WIDTH-1:0]               predDir_i,
   input  logic [FETCH_WIDTH-1:0]               directCtrl_i,
   input  logic [FETCH_WIDTH-1:0]               btbHit_i,
   input  logic [SIZE_PC-1:0]                   fallThroughPC_i,
   input  logic [SIZE_PC-1:0]                   fetch1NPC_i,
   output logic [FETCH_WIDTH-1:0]               laneKeep_o,
   output logic                                 redirect_o,
   output logic [SIZE_PC-1:0]                   redirectPC_o,
   output logic                                 updValid_o,
   input  logic                                 updReady_i,
   output logic [SIZE_PC-1:0]                   updPC_o,
   output logic [SIZE_PC-1:0]                   updTarget_o,
   output logic [BRANCH_TYPE_LOG-1:0]           updType_o,
   output logic [7:0]                           dropCnt_o
);

   localparam int LANE_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
   localparam int PTR_W  = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
   localparam logic [BRANCH_TYPE_LOG-1:0] COND_BRANCH = '0;

   typedef enum logic {RUN, SQUASH} state_t;

   state_t                      r_state;
   logic                        r_redirect;
   logic [SIZE_PC-1:0]          r_redirectPC;

   logic [FETCH_WIDTH-1:0]      w_taken;
   logic [FETCH_WIDTH-1:0]      w_keepMask;
   logic                        w_found;
   logic [LANE_W-1:0]           w_sel;
   logic [SIZE_PC-1:0]          w_selNPC;
   logic [BRANCH_TYPE_LOG-1:0]  w_selType;
   logic                        w_selDirect;
   logic                        w_selHit;
   logic [SIZE_PC-1:0]          w_selPC;
   logic [SIZE_PC-1:0]          w_corrNPC;
   logic                        w_accept;
   logic                        w_redir;
   logic                        w_push;

   always_comb begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         w_taken[k] = laneValid_i[k] & ctrlInst_i[k] &
            ((ctrlType_i[k*BRANCH_TYPE_LOG +: BRANCH_TYPE_LOG] != COND_BRANCH)
             | predDir_i[k]);
      end
   end

   // Lanes up to and including the first taken one survive.
   always_comb begin
      w_found     = 1'b0;
      w_sel       = '0;
      w_selNPC    = '0;
      w_selType   = '0;
      w_selDirect = 1'b0;
      w_selHit    = 1'b0;
      w_keepMask  = '0;
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         if (!w_found) begin
            w_keepMask[k] = 1'b1;
            if (w_taken[k]) begin
               w_found     = 1'b1;
               w_sel       = LANE_W'(k);
               w_selNPC    = predNPC_i[k*SIZE_PC +: SIZE_PC];
               w_selType   = ctrlType_i[k*BRANCH_TYPE_LOG +: BRANCH_TYPE_LOG];
               w_selDirect = directCtrl_i[k];
               w_selHit    = btbHit_i[k];
            end
         end
      end
   end

   assign w_corrNPC = w_found ? w_selNPC : fallThroughPC_i;
   assign w_selPC   = pc_i + (SIZE_PC'(w_sel) << 2);
   assign w_accept  = fs2Valid_i & ~stall_i & (r_state == RUN) & ~flush_i;
   assign w_redir   = w_accept & (w_corrNPC != fetch1NPC_i);
   assign w_push    = w_accept & w_found & w_selDirect & ~w_selHit;

   assign laneKeep_o = (r_state == RUN) ? (laneValid_i & w_keepMask) : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= RUN;
         r_redirect   <= 1'b0;
         r_redirectPC <= '0;
      end else begin
         r_redirect <= w_redir;
         if (w_redir) begin
            r_redirectPC <= w_corrNPC;
         end
         if (flush_i) begin
            r_state <= RUN;
         end else begin
            case (r_state)
               RUN:     if (w_redir) r_state <= SQUASH;
               SQUASH:  r_state <= RUN;
               default: r_state <= RUN;
            endcase
         end
      end
   end

   assign redirect_o   = r_redirect;
   assign redirectPC_o = r_redirectPC;

   logic [PTR_W:0]               r_wrPtr;
   logic [PTR_W:0]               r_rdPtr;
   logic [SIZE_PC-1:0]           r_memPC  [UPD_DEPTH];
   logic [SIZE_PC-1:0]           r_memTgt [UPD_DEPTH];
   logic [BRANCH_TYPE_LOG-1:0]   r_memTyp [UPD_DEPTH];
   logic [7:0]                   r_dropCnt;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_wr;
   logic w_drop;

   assign w_empty = (r_wrPtr == r_rdPtr);
   assign w_full  = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &
                    (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
   assign w_pop   = ~w_empty & updReady_i;
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign w_wr    = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & w_full & ~w_pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         r_dropCnt <= '0;
         for (int i = 0; i < UPD_DEPTH; i++) begin
            r_memPC[i]  <= '0;
            r_memTgt[i] <= '0;
            r_memTyp[i] <= '0;
         end
      end else begin
         if (w_wr) begin
            r_memPC[r_wrPtr[PTR_W-1:0]]  <= w_selPC;
            r_memTgt[r_wrPtr[PTR_W-1:0]] <= w_selNPC;
            r_memTyp[r_wrPtr[PTR_W-1:0]] <= w_selType;
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (w_drop && (r_dropCnt != 8'hFF)) begin
            r_dropCnt <= r_dropCnt + 8'd1;
         end
      end
   end

   assign updValid_o  = ~w_empty;
   assign updPC_o     = r_memPC[r_rdPtr[PTR_W-1:0]];
   assign updTarget_o = r_memTgt[r_rdPtr[PTR_W-1:0]];
   assign updType_o   = r_memTyp[r_rdPtr[PTR_W-1:0]];
   assign dropCnt_o   = r_dropCnt;

endmodule

// File: tb/tb_fs2_redirect_ctrl.sv
// Directed bench for fs2_redirect_ctrl with a queue scoreboard
// for the BTB-update path.
module tb_fs2_redirect_ctrl;

   localparam int FW  = 4;
   localparam int PCW = 64;
   localparam int BTL = 2;

   localparam logic [1:0] T_COND = 2'd0;
   localparam logic [1:0] T_RET  = 2'd1;
   localparam logic [1:0] T_JMP  = 2'd3;

   typedef struct {
      logic [PCW-1:0] pc;
      logic [PCW-1:0] tgt;
      logic [BTL-1:0] typ;
   } upd_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              flush;
   logic              fs2Valid;
   logic              stall;
   logic [PCW-1:0]    pc;
   logic [FW-1:0]     laneValid;
   logic [FW-1:0]     ctrlInst;
   logic [FW*BTL-1:0] ctrlType;
   logic [FW*PCW-1:0] predNPC;
   logic [FW-1:0]     predDir;
   logic [FW-1:0]     directCtrl;
   logic [FW-1:0]     btbHit;
   logic [PCW-1:0]    fallThroughPC;
   logic [PCW-1:0]    fetch1NPC;
   logic [FW-1:0]     laneKeep;
   logic              redirect;
   logic [PCW-1:0]    redirectPC;
   logic              updValid;
   logic              updReady;
   logic [PCW-1:0]    updPC;
   logic [PCW-1:0]    updTarget;
   logic [BTL-1:0]    updType;
   logic [7:0]        dropCnt;

   int   n_assert = 0;
   int   n_fail   = 0;
   upd_t exp_q[$];
   int   cyc;

   always #5 clk = ~clk;

   fs2_redirect_ctrl #(
      .FETCH_WIDTH(FW), .SIZE_PC(PCW),
      .BRANCH_TYPE_LOG(BTL), .UPD_DEPTH(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .flush_i(flush),
      .fs2Valid_i(fs2Valid), .stall_i(stall), .pc_i(pc),
      .laneValid_i(laneValid), .ctrlInst_i(ctrlInst),
      .ctrlType_i(ctrlType), .predNPC_i(predNPC),
      .predDir_i(predDir), .directCtrl_i(directCtrl),
      .btbHit_i(btbHit), .fallThroughPC_i(fallThroughPC),
      .fetch1NPC_i(fetch1NPC), .laneKeep_o(laneKeep),
      .redirect_o(redirect), .redirectPC_o(redirectPC),
      .updValid_o(updValid), .updReady_i(updReady),
      .updPC_o(updPC), .updTarget_o(updTarget),
      .updType_o(updType), .dropCnt_o(dropCnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_bundle();
      fs2Valid      = 1'b0;
      pc            = '0;
      laneValid     = '0;
      ctrlInst      = '0;
      ctrlType      = '0;
      predNPC       = '0;
      predDir       = '0;
      directCtrl    = '0;
      btbHit        = '0;
      fallThroughPC = '0;
      fetch1NPC     = '0;
   endtask

   task automatic seq_bundle(input logic [PCW-1:0] p,
                             input logic [PCW-1:0] f1);
      clear_bundle();
      fs2Valid      = 1'b1;
      pc            = p;
      laneValid     = 4'b1111;
      fallThroughPC = p + 64'h10;
      fetch1NPC     = f1;
   endtask

   task automatic set_lane(input int k, input logic [1:0] typ,
                           input logic [PCW-1:0] npc, input logic dir,
                           input logic direct, input logic hit);
      ctrlInst[k]             = 1'b1;
      ctrlType[k*BTL +: BTL]  = typ;
      predNPC[k*PCW +: PCW]   = npc;
      predDir[k]              = dir;
      directCtrl[k]           = direct;
      btbHit[k]               = hit;
   endtask

   task automatic push_exp(input logic [PCW-1:0] p, input logic [PCW-1:0] t,
                           input logic [BTL-1:0] ty);
      upd_t e;
      e.pc  = p;
      e.tgt = t;
      e.typ = ty;
      exp_q.push_back(e);
   endtask

   task automatic drain(input int maxc, input string tag, output int n);
      upd_t e;
      n = 0;
      updReady = 1'b1;
      while (updValid === 1'b1 && n < maxc) begin
         if (exp_q.size() == 0) begin
            chk({tag, "_extra"}, 64'(updPC), 64'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk({tag, "_pc"}, updPC, e.pc);
            chk({tag, "_tgt"}, updTarget, e.tgt);
            chk({tag, "_typ"}, 64'(updType), 64'(e.typ));
         end
         step();
         n++;
      end
      updReady = 1'b0;
      chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
      chk({tag, "_valid_end"}, 64'(updValid), 64'd0);
   endtask

   initial begin
      reset_n  = 1'b0;
      flush    = 1'b0;
      stall    = 1'b0;
      updReady = 1'b0;
      clear_bundle();
      step();
      step();
      chk("rst_redirect", 64'(redirect), 64'd0);
      chk("rst_redirectPC", redirectPC, 64'd0);
      chk("rst_updValid", 64'(updValid), 64'd0);
      chk("rst_updPC", updPC, 64'd0);
      chk("rst_dropCnt", 64'(dropCnt), 64'd0);
      reset_n = 1'b1;
      step();

      // Plain sequential bundle
      seq_bundle(64'h1000, 64'h1010);
      #1;
      chk("seq_keep", 64'(laneKeep), 64'hF);
      step();
      clear_bundle();
      chk("seq_redirect", 64'(redirect), 64'd0);
      chk("seq_updValid", 64'(updValid), 64'd0);

      // JAL in lane 1 missing in the BTB
      seq_bundle(64'h1000, 64'h1010);
      set_lane(1, T_JMP, 64'h2000, 1'b0, 1'b1, 1'b0);
      #1;
      chk("jal_keep", 64'(laneKeep), 64'h3);
      push_exp(64'h1004, 64'h2000, T_JMP);
      step();
      seq_bundle(64'h1010, 64'h9990);
      set_lane(0, T_JMP, 64'h7000, 1'b0, 1'b1, 1'b0);
      #1;
      chk("jal_redirect", 64'(redirect), 64'd1);
      chk("jal_redirectPC", redirectPC, 64'h2000);
      chk("jal_squash_keep", 64'(laneKeep), 64'h0);
      chk("jal_updValid", 64'(updValid), 64'd1);
      step();
      clear_bundle();
      chk("jal_pulse_end", 64'(redirect), 64'd0);
      drain(8, "jal_drain", cyc);

      // Not-taken cond branch, predicted return hit
      seq_bundle(64'h1000, 64'h3000);
      set_lane(0, T_COND, 64'h1800, 1'b0, 1'b1, 1'b0);
      set_lane(2, T_RET, 64'h3000, 1'b0, 1'b0, 1'b1);
      #1;
      chk("ret_keep", 64'(laneKeep), 64'h7);
      step();
      clear_bundle();
      chk("ret_redirect", 64'(redirect), 64'd0);
      chk("ret_updValid", 64'(updValid), 64'd0);

      // Six missed JALs against a blocked BTB
      for (int i = 0; i < 6; i++) begin
         seq_bundle(64'h4000 + 64'(i) * 64'h10, 64'h5000 + 64'(i) * 64'h100);
         set_lane(0, T_JMP, 64'h5000 + 64'(i) * 64'h100, 1'b0, 1'b1, 1'b0);
         if (i < 4) push_exp(64'h4000 + 64'(i) * 64'h10,
                             64'h5000 + 64'(i) * 64'h100, T_JMP);
         step();
      end
      clear_bundle();
      chk("full_dropCnt", 64'(dropCnt), 64'd2);
      chk("full_redirect", 64'(redirect), 64'd0);
      drain(10, "full_drain", cyc);
      chk("full_drain_rate", 64'(cyc), 64'd4);

      // Stall holds the bundle; evaluated once on release
      seq_bundle(64'h8000, 64'h8010);
      set_lane(0, T_JMP, 64'h8800, 1'b0, 1'b1, 1'b0);
      stall = 1'b1;
      #1;
      chk("stall_keep", 64'(laneKeep), 64'h1);
      step();
      step();
      chk("stall_redirect", 64'(redirect), 64'd0);
      chk("stall_updValid", 64'(updValid), 64'd0);
      stall = 1'b0;
      push_exp(64'h8000, 64'h8800, T_JMP);
      step();
      clear_bundle();
      chk("unstall_redirect", 64'(redirect), 64'd1);
      chk("unstall_redirectPC", redirectPC, 64'h8800);
      step();
      chk("unstall_pulse_end", 64'(redirect), 64'd0);
      drain(8, "stall_drain", cyc);

      // Flush wins over accept
      seq_bundle(64'h9000, 64'h9010);
      set_lane(1, T_JMP, 64'h9800, 1'b0, 1'b1, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      clear_bundle();
      chk("flushacc_redirect", 64'(redirect), 64'd0);
      chk("flushacc_updValid", 64'(updValid), 64'd0);

      // Flush during SQUASH restores RUN
      seq_bundle(64'h1000, 64'h1010);
      set_lane(2, T_JMP, 64'h6000, 1'b0, 1'b1, 1'b1);
      #1;
      chk("fl_keep", 64'(laneKeep), 64'h7);
      step();
      clear_bundle();
      laneValid = 4'b1111;
      flush = 1'b1;
      #1;
      chk("fl_redirect", 64'(redirect), 64'd1);
      chk("fl_redirectPC", redirectPC, 64'h6000);
      chk("fl_squash_keep", 64'(laneKeep), 64'h0);
      step();
      flush = 1'b0;
      seq_bundle(64'h6000, 64'h6010);
      #1;
      chk("fl_after_redirect", 64'(redirect), 64'd0);
      chk("fl_after_keep", 64'(laneKeep), 64'hF);
      chk("fl_after_updValid", 64'(updValid), 64'd0);
      step();
      clear_bundle();
      chk("fl_next_redirect", 64'(redirect), 64'd0);

      // Async reset with 3 queued entries and SQUASH pending
      for (int i = 0; i < 3; i++) begin
         seq_bundle(64'hA000 + 64'(i) * 64'h10, 64'hA100 + 64'(i));
         set_lane(0, T_JMP, 64'hA100 + 64'(i), 1'b0, 1'b1, 1'b0);
         step();
      end
      seq_bundle(64'hA800, 64'h0);
      set_lane(0, T_JMP, 64'hC000, 1'b0, 1'b1, 1'b1);
      step();
      clear_bundle();
      laneValid = 4'b1111;
      #1;
      chk("prerst_redirect", 64'(redirect), 64'd1);
      chk("prerst_updValid", 64'(updValid), 64'd1);
      chk("prerst_keep", 64'(laneKeep), 64'h0);
      reset_n = 1'b0;
      #1;
      chk("arst_redirect", 64'(redirect), 64'd0);
      chk("arst_redirectPC", redirectPC, 64'd0);
      chk("arst_updValid", 64'(updValid), 64'd0);
      chk("arst_updPC", updPC, 64'd0);
      chk("arst_updTarget", updTarget, 64'd0);
      chk("arst_updType", 64'(updType), 64'd0);
      chk("arst_dropCnt", 64'(dropCnt), 64'd0);
      chk("arst_keep", 64'(laneKeep), 64'hF);
      exp_q.delete();
      step();
      reset_n = 1'b1;
      seq_bundle(64'hB000, 64'hB010);
      #1;
      chk("post_keep", 64'(laneKeep), 64'hF);
      step();
      clear_bundle();
      chk("post_redirect", 64'(redirect), 64'd0);
      chk("post_updValid", 64'(updValid), 64'd0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
